// File: rtl/la_dump_pkg.sv
// Shared constants and types for the logic-analyzer dump sequencer.
// Frame sync bytes, FSM state codes and the frame phase enum.
package la_dump_pkg;

    localparam logic [7:0] SYNC0 = 8'hAA;
    localparam logic [7:0] SYNC1 = 8'h55;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SEND  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [2:0] {
        PH_SYNC0,
        PH_SYNC1,
        PH_LENH,
        PH_LENL,
        PH_PAY,
        PH_CHK
    } phase_t;

endpackage

// File: rtl/la_dump_if.sv
// Sample-RAM read port plus UART transmitter byte port.
// master = sequencer side, slave = RAM/transmitter side.
interface la_dump_if #(
    parameter int ADDR_W = 10
);

    logic              UartEN;
    logic [7:0]        UartData;
    logic              RdCLK;
    logic [ADDR_W-1:0] RdAddr;
    logic [7:0]        RdData;

    modport master (
        output UartEN,
        output UartData,
        output RdAddr,
        input  RdCLK,
        input  RdData
    );

    modport slave (
        input  UartEN,
        input  UartData,
        input  RdAddr,
        output RdCLK,
        output RdData
    );

endinterface

// File: rtl/la_byte_prefetch.sv
// One-entry payload prefetch from the capture RAM.
// Address wraps naturally at the end of the circular buffer.
module la_byte_prefetch #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              take,
    input  logic              last,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [7:0]        data
);

    logic issue_q;
    logic cap_q;
    logic valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr <= '0;
            issue_q <= 1'b0;
            cap_q   <= 1'b0;
            valid_q <= 1'b0;
            data    <= 8'h00;
        end else begin
            cap_q   <= issue_q;
            issue_q <= 1'b0;
            if (cap_q && !valid_q) begin
                data    <= rd_data;
                valid_q <= 1'b1;
            end
            // Refill is issued on the same edge the held byte is consumed
            if (load) begin
                rd_addr <= start_addr;
                issue_q <= 1'b1;
                valid_q <= 1'b0;
            end else if (take) begin
                valid_q <= 1'b0;
                if (!last) begin
                    rd_addr <= rd_addr + ADDR_W'(1);
                    issue_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/la_dump_sequencer.sv
// Streams a framed block of captured samples to the UART transmitter.
// Frame: AA 55 LEN_HI LEN_LO payload CHK, paced by RdCLK rises.
module la_dump_sequencer
    import la_dump_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              SendingCLK,
    input  logic              Init,
    input  logic              Start,
    input  logic [ADDR_W-1:0] StartAddr,
    input  logic [ADDR_W:0]   Len,
    la_dump_if.master         bus,
    output logic              Busy,
    output logic              Done
);

    logic [1:0]      state;
    phase_t          phase;
    logic [ADDR_W:0] cnt;
    logic [7:0]      chk;
    logic            rdclk_q;
    logic            en_q;
    logic [7:0]      data_q;
    logic [15:0]     len16;
    logic            rise;
    logic            fall;
    logic            pay_more;
    logic            pf_load;
    logic            pf_take;
    logic            pf_last;
    logic [7:0]      pf_data;

    assign rise     = bus.RdCLK & ~rdclk_q;
    assign fall     = ~bus.RdCLK & rdclk_q;
    // cnt is untouched until the first payload byte, so it still holds Len
    assign len16    = 16'(cnt);
    assign pay_more = (cnt != '0);
    assign pf_load  = (state == ST_IDLE) && Start && (Len != '0);
    assign pf_take  = (state == ST_SEND) && rise && pay_more
                   && ((phase == PH_LENL) || (phase == PH_PAY));
    assign pf_last  = (cnt == (ADDR_W+1)'(1));

    assign bus.UartEN   = en_q;
    assign bus.UartData = data_q;

    la_byte_prefetch #(
        .ADDR_W (ADDR_W)
    ) u_pf (
        .clk        (SendingCLK),
        .rst        (Init),
        .load       (pf_load),
        .start_addr (StartAddr),
        .take       (pf_take),
        .last       (pf_last),
        .rd_addr    (bus.RdAddr),
        .rd_data    (bus.RdData),
        .data       (pf_data)
    );

    always_ff @(posedge SendingCLK) begin
        if (Init) begin
            state   <= ST_IDLE;
            phase   <= PH_SYNC0;
            cnt     <= '0;
            chk     <= 8'h00;
            rdclk_q <= 1'b0;
            en_q    <= 1'b0;
            data_q  <= 8'hFF;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            rdclk_q <= bus.RdCLK;
            Done    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        state  <= ST_SEND;
                        phase  <= PH_SYNC0;
                        cnt    <= Len;
                        chk    <= 8'h00;
                        en_q   <= 1'b1;
                        data_q <= SYNC0;
                        Busy   <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (rise) begin
                        unique case (phase)
                            PH_SYNC0: begin
                                data_q <= SYNC1;
                                phase  <= PH_SYNC1;
                            end
                            PH_SYNC1: begin
                                data_q <= len16[15:8];
                                chk    <= chk ^ len16[15:8];
                                phase  <= PH_LENH;
                            end
                            PH_LENH: begin
                                data_q <= len16[7:0];
                                chk    <= chk ^ len16[7:0];
                                phase  <= PH_LENL;
                            end
                            PH_LENL, PH_PAY: begin
                                if (pay_more) begin
                                    data_q <= pf_data;
                                    chk    <= chk ^ pf_data;
                                    cnt    <= cnt - (ADDR_W+1)'(1);
                                    phase  <= PH_PAY;
                                end else begin
                                    data_q <= chk;
                                    phase  <= PH_CHK;
                                end
                            end
                            PH_CHK: begin
                                en_q  <= 1'b0;
                                state <= ST_DRAIN;
                            end
                            default: phase <= PH_SYNC0;
                        endcase
                    end
                end
                ST_DRAIN: begin
                    // Falling RdCLK: the final stop bit is on the line
                    if (fall) begin
                        state <= ST_IDLE;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/la_dump_sequencer.md
# la_dump_sequencer

Frame sequencer that streams a block of captured samples from the logic analyzer's sample RAM to the host over the byte-serial UART transmitter. On a start request it drives the transmitter's enable and data inputs through one complete frame: two sync bytes, a 16-bit length, the payload read from a circular capture buffer, and an XOR checksum. It paces itself only on the transmitter's `RdCLK` indication and sits between the capture memory and the UART transmitter.

## Interface
- `ADDR_W`, default 10: sample RAM address width; buffer depth is 2^ADDR_W bytes.
- `SendingCLK`, in, 1: the only clock. It is the same clock that drives the UART transmitter.
- `Init`, in, 1: reset, synchronous, active-high.
- `Start`, in, 1: one-cycle request to begin a frame. It is ignored while `Busy`.
- `StartAddr`, in, ADDR_W: RAM address of the first payload byte. Sampled with `Start`.
- `Len`, in, ADDR_W+1: payload byte count, 0..2^ADDR_W. Sampled with `Start`.
- `RdAddr`, out, ADDR_W: sample RAM read address.
- `RdData`, in, 8: sample RAM data. Valid one cycle after `RdAddr`.
- `UartEN`, out, 1: transmitter enable.
- `UartData`, out, 8: byte presented to the transmitter.
- `RdCLK`, in, 1: transmitter indication. It is high from stop-bit phase until the transmitter returns to idle.
- `Busy`, out, 1: a frame is in progress.
- `Done`, out, 1: one-cycle pulse when the frame is fully on the line.

## Operation
- Frame format: 0xAA, 0x55, LEN_HI, LEN_LO, payload[0..Len-1], CHK.
  - LEN is `Len` zero-extended to 16 bits.
  - CHK is the XOR of LEN_HI, LEN_LO and all payload bytes.
- Payload byte i is read from RAM address (StartAddr + i) mod 2^ADDR_W, so the address wraps at the end of the buffer.
- `Len`=0 produces the 5-byte frame AA 55 00 00 00.
- The block samples `RdCLK` into a register. A rising edge (`rdclk_q`=0, `RdCLK`=1) means the current byte has been serialised and the next byte may be presented.
- States:
  - IDLE: on `Start`, latch the request, set `UartData`=0xAA and `UartEN`=1, and begin fetching payload[0]. Go to SEND.
  - SEND: on each `RdCLK` rise, if bytes remain, load the next frame byte into `UartData` and stay in SEND. After the rise that ends CHK, drop `UartEN` and go to DRAIN.
  - DRAIN: wait for the `RdCLK` falling edge, which marks the last stop bit done. Pulse `Done` and go to IDLE.
- `UartEN` stays high continuously from the first byte through the rise that ends CHK. There are no idle gaps between bytes.
- Payload prefetch: a one-entry buffer holds the next payload byte. It is refilled on the cycle after that byte moves into `UartData`, so a payload byte is always ready before the `RdCLK` rise that needs it.
- Checksum: an 8-bit accumulator, cleared on `Start`. It XORs each LEN and payload byte as that byte is loaded into `UartData`.
- Byte counter: width ADDR_W+1. It counts down the payload remaining; header and checksum bytes are tracked by a 3-bit phase field.

## Timing
- Reset values: `UartEN`=0, `UartData`=0xFF, `RdAddr`=0, `Busy`=0, `Done`=0. State is IDLE, the accumulator is 0, and `rdclk_q`=0.
- `Init` at any time, including mid-frame or coincident with `Start`, takes effect at the next edge: all outputs go to their reset values. Any byte the transmitter already holds is finished by the transmitter itself.
- Start latency: `UartEN`=1 and `UartData`=0xAA appear on the clock edge that samples `Start`. `Busy`=1 from that edge until the edge that drives `Done`.
- Byte update: `UartData` changes exactly 1 cycle after the cycle in which `RdCLK` is first seen high. This is within 2 cycles of the transmitter's own rise, before it re-enters its idle index.
- RAM read: `RdAddr` is issued in cycle n and `RdData` is captured in cycle n+1. A `RdAddr` wrap from 2^ADDR_W−1 to 0 needs no extra cycle.
- `Done` is high exactly 1 cycle; `Busy` falls on the same edge. A new `Start` is accepted on the following cycle.
- `Start` while `Busy`=1 is ignored; no state changes.

## Structure
- Package `la_dump_pkg` holds:
  - SYNC0=8'hAA and SYNC1=8'h55;
  - the state enum (IDLE, SEND, DRAIN);
  - the phase enum (SYNC0, SYNC1, LENH, LENL, PAY, CHK).
- Sub-module `la_byte_prefetch` holds the RAM address counter with wrap, the one-entry buffer with its valid flag, and a `take` strobe input.
- The top level holds the FSM, the `RdCLK` edge detector, the checksum and the byte counter.

## Test plan
- `Len`=3, `StartAddr`=0x010, RAM[0x10..0x12]=01 02 04 → line bytes AA 55 00 03 01 02 04 04; one `Done` pulse.
- `Len`=0 → bytes AA 55 00 00 00, and no RAM reads issued.
- `ADDR_W`=10, `StartAddr`=0x3FE, `Len`=4 → `RdAddr` sequence 3FE, 3FF, 000, 001; CHK correct.
- `Start` pulsed mid-frame → ignored; the frame is byte-identical to the unperturbed run; exactly one `Done`.
- `Init` asserted during payload byte 2 → next edge gives `UartEN`=0, `UartData`=FF, `Busy`=0; a fresh `Start` then yields a complete correct frame.
- Continuous framing: the bench checks `UartEN` never drops between AA and CHK, and that the serial line shows no idle bit between bytes.
